// File: rtl/pong_pkg.sv
// Shared Pong definitions: match-state encoding, winner codes and default playfield size
// used by the match sequencer, ball block and paddle blocks.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SERVE     = 2'd1,
    ST_RUNNING   = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int DEFAULT_GAME_WIDTH  = 40;
  localparam int DEFAULT_GAME_HEIGHT = 30;

endpackage

// File: rtl/pong_game_ctrl_paddle_hit.sv
// Combinational paddle hit test: is the ball row inside [paddle_y, paddle_y + height)?
module pong_paddle_hit #(
  parameter int c_PADDLE_HEIGHT = 6
) (
  input  logic [5:0] ball_y,
  input  logic [5:0] paddle_y,
  output logic       hit
);

  logic [6:0] paddle_end;

  // Extra bit so a paddle near row 63 does not wrap back to the top.
  assign paddle_end = {1'b0, paddle_y} + 7'(c_PADDLE_HEIGHT);
  assign hit        = (ball_y >= paddle_y) && ({1'b0, ball_y} < paddle_end);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve delay, miss detection at both paddle columns,
// score keeping and winner declaration.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int c_GAME_WIDTH    = DEFAULT_GAME_WIDTH,
  parameter int c_GAME_HEIGHT   = DEFAULT_GAME_HEIGHT,
  parameter int c_PADDLE_HEIGHT = 6,
  parameter int c_SERVE_DELAY   = 25000000,
  parameter int c_SCORE_LIMIT   = 9
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic [5:0] i_Ball_X,
  input  logic [5:0] i_Ball_Y,
  input  logic [5:0] i_Paddle_Y_P1,
  input  logic [5:0] i_Paddle_Y_P2,
  output logic       o_Game_Active,
  output logic [3:0] o_P1_Score,
  output logic [3:0] o_P2_Score,
  output logic [1:0] o_Winner,
  output logic [1:0] o_State
);

  localparam int         c_CNT_W    = (c_SERVE_DELAY > 1) ? $clog2(c_SERVE_DELAY) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_SERVE_DELAY - 1);
  localparam logic [3:0] c_LIMIT    = 4'(c_SCORE_LIMIT);
  localparam logic [5:0] c_RIGHT_X  = 6'(c_GAME_WIDTH - 1);

  if (c_SCORE_LIMIT < 1 || c_SCORE_LIMIT > 15 || c_PADDLE_HEIGHT > c_GAME_HEIGHT
      || c_SERVE_DELAY < 1) begin : g_bad_params
    $error("pong_game_ctrl: illegal parameter combination");
  end

  state_e               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]           p1_score_q, p1_score_d;
  logic [3:0]           p2_score_q, p2_score_d;
  logic [1:0]           winner_q, winner_d;
  logic                 active_q, active_d;

  logic                 p1_hit, p2_hit;
  logic                 left_miss, right_miss;
  logic [3:0]           p1_score_inc, p2_score_inc;

  pong_paddle_hit #(.c_PADDLE_HEIGHT(c_PADDLE_HEIGHT)) u_hit_p1 (
    .ball_y   (i_Ball_Y),
    .paddle_y (i_Paddle_Y_P1),
    .hit      (p1_hit)
  );

  pong_paddle_hit #(.c_PADDLE_HEIGHT(c_PADDLE_HEIGHT)) u_hit_p2 (
    .ball_y   (i_Ball_Y),
    .paddle_y (i_Paddle_Y_P2),
    .hit      (p2_hit)
  );

  assign left_miss    = (i_Ball_X == 6'd0) && !p1_hit;
  assign right_miss   = (i_Ball_X == c_RIGHT_X) && !p2_hit;
  assign p1_score_inc = (p1_score_q == c_LIMIT) ? p1_score_q : p1_score_q + 4'd1;
  assign p2_score_inc = (p2_score_q == c_LIMIT) ? p2_score_q : p2_score_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    winner_d   = winner_q;

    unique case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (i_Start) begin
          state_d    = ST_SERVE;
          cnt_d      = '0;
          p1_score_d = '0;
          p2_score_d = '0;
          winner_d   = WIN_NONE;
        end
      end
      ST_SERVE: begin
        if (cnt_q == c_CNT_LAST) begin
          state_d = ST_RUNNING;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUNNING: begin
        // Leaving RUNNING on the first miss cycle is what keeps a parked ball from scoring twice.
        if (left_miss) begin
          p2_score_d = p2_score_inc;
          cnt_d      = '0;
          if (p2_score_inc == c_LIMIT) begin
            state_d  = ST_GAME_OVER;
            winner_d = WIN_P2;
          end else begin
            state_d = ST_SERVE;
          end
        end else if (right_miss) begin
          p1_score_d = p1_score_inc;
          cnt_d      = '0;
          if (p1_score_inc == c_LIMIT) begin
            state_d  = ST_GAME_OVER;
            winner_d = WIN_P1;
          end else begin
            state_d = ST_SERVE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    active_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      p1_score_q <= '0;
      p2_score_q <= '0;
      winner_q   <= WIN_NONE;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p1_score_q <= p1_score_d;
      p2_score_q <= p2_score_d;
      winner_q   <= winner_d;
      active_q   <= active_d;
    end
  end

  assign o_Game_Active = active_q;
  assign o_P1_Score    = p1_score_q;
  assign o_P2_Score    = p2_score_q;
  assign o_Winner      = winner_q;
  assign o_State       = state_q;

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Match sequencer for Pong: owns the game-active enable that drives the ball-motion block, and watches ball and paddle positions.
- Detects misses at the left and right paddle columns, updates both scores, and holds the ball at centre for a serve delay after each point.
- Declares a winner when a player reaches the score limit.
- Sits between the debounced start button, the ball block and the two paddle blocks; feeds the score/winner display.

Parameters:
- c_GAME_WIDTH, 40, playfield columns (ball X range 0..c_GAME_WIDTH-1)
- c_GAME_HEIGHT, 30, playfield rows
- c_PADDLE_HEIGHT, 6, paddle length in rows
- c_SERVE_DELAY, 25000000, cycles the ball is held at centre before each serve
- c_SCORE_LIMIT, 9, points needed to win (1..15)

Ports:
- i_Clk, input, 1, system clock
- i_Rst, input, 1, asynchronous active-high reset
- i_Start, input, 1, debounced one-cycle start pulse
- i_Ball_X, input, 6, ball column from the ball block
- i_Ball_Y, input, 6, ball row from the ball block
- i_Paddle_Y_P1, input, 6, top row of the left paddle (column 0)
- i_Paddle_Y_P2, input, 6, top row of the right paddle (column c_GAME_WIDTH-1)
- o_Game_Active, output, 1, enable to the ball block; low holds the ball at centre
- o_P1_Score, output, 4, left player score
- o_P2_Score, output, 4, right player score
- o_Winner, output, 2, 00 none, 01 P1, 10 P2
- o_State, output, 2, current state, for debug and display

Behaviour:
- Reset (async, i_Rst=1): state IDLE, o_Game_Active=0, both scores 0, o_Winner=00, serve counter 0. Reset mid-rally or mid-serve aborts immediately with the same values.
- States and encoding (o_State): IDLE=0, SERVE=1, RUNNING=2, GAME_OVER=3. All outputs are registered.
- IDLE: o_Game_Active=0. On i_Start=1, go to SERVE with counter cleared and scores cleared.
- SERVE: o_Game_Active=0; counter increments each cycle. When counter == c_SERVE_DELAY-1, go to RUNNING and clear the counter. o_Game_Active rises on the cycle the state becomes RUNNING. Serve lasts exactly c_SERVE_DELAY cycles.
- Hit test, P1: i_Ball_Y >= i_Paddle_Y_P1 and i_Ball_Y < i_Paddle_Y_P1 + c_PADDLE_HEIGHT. The sum is computed 7 bits wide, so there is no wrap. P2 uses the same test against i_Paddle_Y_P2.
- RUNNING, left miss: i_Ball_X == 0 and P1 hit false -> increment P2 score.
- RUNNING, right miss: i_Ball_X == c_GAME_WIDTH-1 and P2 hit false -> increment P1 score.
- RUNNING, after a miss: if the new score equals c_SCORE_LIMIT, go to GAME_OVER and set o_Winner to the scoring player; otherwise go to SERVE.
- RUNNING, o_Game_Active timing: it drops on the cycle after the miss is sampled, i.e. one-cycle detect latency.
- RUNNING, hit at an edge column: no action; the ball block performs the bounce.
- Single-count guarantee: leaving RUNNING on the first miss cycle means a ball resting at column 0 for many cycles scores only once. In SERVE the ball sits at the centre column, so a miss cannot retrigger.
- Both edge conditions true in the same cycle: impossible for c_GAME_WIDTH > 1. If it occurs, the left-miss check has priority.
- i_Start is ignored in SERVE and RUNNING.
- GAME_OVER: o_Game_Active=0; scores and o_Winner hold. i_Start=1 clears scores and o_Winner and goes to SERVE.
- Scores saturate at c_SCORE_LIMIT and never wrap.

Decomposition:
- Shared package pong_pkg:
  - state encoding constants (IDLE, SERVE, RUNNING, GAME_OVER)
  - winner encodings
  - default c_GAME_WIDTH and c_GAME_HEIGHT, shared with the ball and paddle blocks
- One sub-module, pong_paddle_hit: combinational hit test with inputs ball Y, paddle Y and c_PADDLE_HEIGHT. It is instantiated twice.
- The serve counter and FSM stay in the top module.

Test Plan:
- Reset while RUNNING with scores 3/2 -> next sample shows o_State=0, o_Game_Active=0, scores 0/0, o_Winner=00.
- Start pulse in IDLE with c_SERVE_DELAY=4 -> o_State=1 for exactly 4 cycles; o_Game_Active=1 on cycle 5; scores 0/0.
- RUNNING, Ball_X=0, Ball_Y=10, Paddle_Y_P1=12 (miss); condition held 50 cycles -> P2 score 1 exactly once, o_State=SERVE next cycle, o_Game_Active=0.
- RUNNING, Ball_X=39, Ball_Y=17, Paddle_Y_P2=12 (hit, rows 12..17); Ball_Y=18 on the next rally -> no score for Y=17; P1 score +1 for Y=18.
- c_SCORE_LIMIT=2, P1 scores twice -> o_State=GAME_OVER, o_Winner=01, o_P1_Score=2. Start pulse -> scores 0/0, o_Winner=00, o_State=SERVE.
- Paddle_Y_P1=60, Ball_Y=63, Ball_X=0 -> hit (7-bit sum 66, no wrap), no score change.
